path_replay_ctrl: RTL and testbench
===================================

Name: path_replay_ctrl

Overview:
- Sequencer for the 8-bit location stack ({x[7:4], y[3:0]}) used by the maze solver.
- During solve: forwards solver push/pop to the stack, guards the stack against overflow and underflow, and tracks depth.
- On path found: issues the one-cycle stack `done` pulse, then pops the stored path one location per handshake onto a valid/ready move port.
- Sits between the solver FSM, the stack, and the move/display consumer.

Parameters:
- LOC_W, 8: location width, {x, y} nibbles.
- MAX_LEN, 63: maximum stored entries; the stack head pointer is 6 bits and must not wrap.
- CNT_W, 6: depth/replay counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  begin a solve run; sampled in IDLE only.
- slv_push  in  1  solver push request.
- slv_pop  in  1  solver pop (backtrack) request.
- slv_loc  in  LOC_W  location to push.
- slv_found  in  1  solver reached the goal.
- slv_fail  in  1  solver exhausted all paths.
- stk_rst  out  1  active-high clear to the stack.
- stk_push  out  1  stack push.
- stk_pop  out  1  stack pop.
- stk_done  out  1  stack mode switch to queue order.
- stk_locIn  out  LOC_W  stack write data.
- stk_locOut  in  LOC_W  stack read data; registered by the stack on the pop edge.
- stk_empty  in  1  stack empty flag.
- mv_valid  out  1  replay location valid.
- mv_loc  out  LOC_W  replay location.
- mv_ready  in  1  consumer accepts mv_loc.
- depth  out  CNT_W  current stored entries.
- overflow  out  1  sticky: push attempted at MAX_LEN.
- finish  out  1  replay complete; sticky.
- fail  out  1  run failed; sticky.

Behaviour:
- Reset (rst=0 at a rising edge):
  - State goes to IDLE.
  - All outputs 0: depth=0, mv_loc=0, overflow/finish/fail=0, stk_* =0.
- Reset mid-run aborts any state, SOLVE or REPLAY, at the next edge.
- States: IDLE, CLEAR, SOLVE, DONE_ISSUE, R_POP, R_WAIT, R_HOLD, FINISH, FAIL.
- IDLE:
  - start=1 → CLEAR. Otherwise stay.
- CLEAR:
  - stk_rst=1 for exactly one cycle; depth←0.
  - → SOLVE.
- SOLVE (stack outputs are combinational from solver inputs, gated):
  - Push with depth<MAX_LEN: stk_push=1, stk_locIn=slv_loc, depth+1.
  - Push with depth==MAX_LEN: not forwarded; overflow←1 → FAIL.
  - Pop with depth>0: stk_pop=1, depth−1. Pop with depth==0: dropped, no effect.
  - push && pop in the same cycle: push forwarded, pop dropped (matches stack priority).
  - slv_fail → FAIL.
  - slv_found → DONE_ISSUE. A push/pop in the same cycle as found is still forwarded first.
  - found && fail in the same cycle: fail wins.
- DONE_ISSUE:
  - stk_done=1 for exactly one cycle; no push/pop; replay count←0.
  - depth==0 → FINISH; else → R_POP.
- R_POP:
  - stk_pop=1 for one cycle.
  - → R_WAIT.
- R_WAIT:
  - stk_locOut is valid this cycle; mv_loc←stk_locOut.
  - → R_HOLD.
- R_HOLD:
  - mv_valid=1; mv_loc stable until accepted.
  - On mv_ready: count+1, mv_valid drops next cycle.
  - If count+1==depth → FINISH; else → R_POP.
- Replay timing:
  - stk_pop at cycle N; mv_valid at N+2.
  - With mv_ready held high, one location every 3 cycles.
- Replay termination:
  - Governed by the internal count reaching depth, not by stk_empty.
  - stk_empty is ignored outside SOLVE.
  - exactly `depth` locations are emitted.
- FINISH / FAIL:
  - Terminal; finish or fail held at 1 until rst.
  - The stack's queue mode is not cleared by stk_rst, so re-use requires a system reset.
- No stack push/pop/done is ever asserted outside SOLVE/DONE_ISSUE/R_POP.

Optional Feature:
- REPLAY_REVERSE_EN defined:
  - DONE_ISSUE is skipped; stk_done is never asserted.
  - Replay pops in stack order: last pushed location emitted first, goal→start.
  - Transition SOLVE→R_POP, or SOLVE→FINISH when depth==0.
- Undefined:
  - Order is start→goal via the stk_done queue switch, as above.

Test Plan:
- Push 0x11, 0x12, 0x22 then found; mv_ready=1 → stk_done pulses 1 cycle; three mv_valid handshakes; mv_valid 2 cycles after each stk_pop; finish=1, depth=3.
- Push 0x11, 0x12, pop, push 0x21, found → depth=2 at found; exactly 2 locations emitted; finish=1.
- 63 pushes then a 64th push → 64th not forwarded (stk_push=0); overflow=1, fail=1, no replay.
- push and pop same cycle at depth=1 → stk_push=1, stk_pop=0, depth=2; pop at depth=0 → stk_pop=0, depth stays 0.
- mv_ready held 0 for 5 cycles in R_HOLD → mv_loc/mv_valid stable, no extra stk_pop; then rst=0 → all outputs 0 next edge, state IDLE.
- REPLAY_REVERSE_EN: push 0x01, 0x02, 0x03, found → stk_done never 1; mv_loc sequence 0x03, 0x02, 0x01.

Source files
------------

// File: rtl/path_replay_ctrl_if.sv
// -----------------------------------------------------------------------------
// path_replay_ctrl_if
//   Bundles the two buses handled by path_replay_ctrl:
//     - the location-stack control/data bus (stk_*)
//     - the valid/ready replay move port (mv_*)
//   Modports:
//     master : the sequencer side (drives stack controls and the move port)
//     slave  : the stack plus move consumer side
//   Signals:
//     stk_rst     active-high stack clear
//     stk_push    stack push strobe
//     stk_pop     stack pop strobe
//     stk_done    stack switch to queue (FIFO) read order
//     stk_locIn   stack write data
//     stk_locOut  stack read data, registered by the stack on the pop edge
//     stk_empty   stack empty flag
//     mv_valid    replay location valid
//     mv_loc      replay location
//     mv_ready    consumer accepts mv_loc
// -----------------------------------------------------------------------------
interface path_replay_ctrl_if #(
    parameter int LOC_W = 8
);
    logic             stk_rst;
    logic             stk_push;
    logic             stk_pop;
    logic             stk_done;
    logic [LOC_W-1:0] stk_locIn;
    logic [LOC_W-1:0] stk_locOut;
    logic             stk_empty;
    logic             mv_valid;
    logic [LOC_W-1:0] mv_loc;
    logic             mv_ready;

    modport master (
        output stk_rst, stk_push, stk_pop, stk_done, stk_locIn,
        output mv_valid, mv_loc,
        input  stk_locOut, stk_empty, mv_ready
    );

    modport slave (
        input  stk_rst, stk_push, stk_pop, stk_done, stk_locIn,
        input  mv_valid, mv_loc,
        output stk_locOut, stk_empty, mv_ready
    );
endinterface

// File: rtl/path_replay_ctrl.sv
// -----------------------------------------------------------------------------
// path_replay_ctrl
//   Sequencer for the maze solver's 8-bit location stack ({x[7:4], y[3:0]}).
//   While solving it forwards solver push/pop to the stack, guarding against
//   overflow and underflow and tracking the stored depth. Once the goal is
//   found it replays the stored path onto a valid/ready move port, one
//   location per handshake.
//
//   Build option:
//     REPLAY_REVERSE_EN  when defined, replay pops in stack order (goal first)
//                        and the stk_done queue switch is never issued.
//                        Default: start-to-goal order via stk_done.
//
//   Ports:
//     clk        system clock, rising edge
//     rst        synchronous active-low reset
//     start      begin a solve run (sampled in IDLE only)
//     slv_push   solver push request, slv_loc carries the location
//     slv_pop    solver pop (backtrack) request
//     slv_found  solver reached the goal
//     slv_fail   solver exhausted all paths
//     bus        stack and move-port bundle (master side)
//     depth      current stored entries
//     overflow   sticky: push attempted with the stack full
//     finish     replay complete (sticky until reset)
//     fail       run failed (sticky until reset)
// -----------------------------------------------------------------------------
module path_replay_ctrl #(
    parameter int LOC_W   = 8,
    parameter int MAX_LEN = 63,
    parameter int CNT_W   = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                slv_push,
    input  logic                slv_pop,
    input  logic [LOC_W-1:0]    slv_loc,
    input  logic                slv_found,
    input  logic                slv_fail,
    path_replay_ctrl_if.master  bus,
    output logic [CNT_W-1:0]    depth,
    output logic                overflow,
    output logic                finish,
    output logic                fail
);

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_CLEAR      = 4'd1;
    localparam logic [3:0] S_SOLVE      = 4'd2;
    localparam logic [3:0] S_DONE_ISSUE = 4'd3;
    localparam logic [3:0] S_R_POP      = 4'd4;
    localparam logic [3:0] S_R_WAIT     = 4'd5;
    localparam logic [3:0] S_R_HOLD     = 4'd6;
    localparam logic [3:0] S_FINISH     = 4'd7;
    localparam logic [3:0] S_FAIL       = 4'd8;

    localparam logic [CNT_W-1:0] MAX_DEPTH = CNT_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    logic [3:0]       state_q,    state_d;
    logic [CNT_W-1:0] depth_q,    depth_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;      // locations accepted during replay
    logic             overflow_q, overflow_d;
    logic [LOC_W-1:0] mv_loc_q,   mv_loc_d;

    logic             stack_full;

    assign stack_full = (depth_q == MAX_DEPTH);

    // NOTE: every signal written here gets a default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        depth_d      = depth_q;
        cnt_d        = cnt_q;
        overflow_d   = overflow_q;
        mv_loc_d     = mv_loc_q;
        bus.stk_rst   = 1'b0;
        bus.stk_push  = 1'b0;
        bus.stk_pop   = 1'b0;
        bus.stk_done  = 1'b0;
        bus.stk_locIn = '0;
        bus.mv_valid  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_CLEAR;
            end

            S_CLEAR: begin
                bus.stk_rst = 1'b1;
                depth_d     = '0;
                cnt_d       = '0;
                state_d     = S_SOLVE;
            end

            S_SOLVE: begin
                // Push has priority over pop, matching the stack itself.
                // A push at full depth is swallowed so the 6-bit head pointer
                // in the stack can never wrap.
                if (slv_push) begin
                    if (!stack_full) begin
                        bus.stk_push  = 1'b1;
                        bus.stk_locIn = slv_loc;
                        depth_d       = depth_q + ONE;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end else if (slv_pop && (depth_q != '0) && !bus.stk_empty) begin
                    bus.stk_pop = 1'b1;
                    depth_d     = depth_q - ONE;
                end

                // A same-cycle push/pop is still forwarded before leaving SOLVE.
                if (slv_fail || (slv_push && stack_full)) begin
                    state_d = S_FAIL;
                end else if (slv_found) begin
`ifdef REPLAY_REVERSE_EN
                    cnt_d   = '0;
                    state_d = (depth_d == '0) ? S_FINISH : S_R_POP;
`else
                    state_d = S_DONE_ISSUE;
`endif
                end
            end

            S_DONE_ISSUE: begin
                bus.stk_done = 1'b1;
                cnt_d        = '0;
                state_d      = (depth_q == '0) ? S_FINISH : S_R_POP;
            end

            S_R_POP: begin
                bus.stk_pop = 1'b1;
                state_d     = S_R_WAIT;
            end

            S_R_WAIT: begin
                // The stack registered its read data on the pop edge.
                mv_loc_d = bus.stk_locOut;
                state_d  = S_R_HOLD;
            end

            S_R_HOLD: begin
                bus.mv_valid = 1'b1;
                if (bus.mv_ready) begin
                    cnt_d   = cnt_q + ONE;
                    // Termination counts handshakes against the stored depth;
                    // the stack's empty flag is not trusted in replay.
                    state_d = ((cnt_q + ONE) == depth_q) ? S_FINISH : S_R_POP;
                end
            end

            S_FINISH: state_d = S_FINISH;
            S_FAIL:   state_d = S_FAIL;

            default:  state_d = S_IDLE;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples the
    // pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            depth_q    <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
            mv_loc_q   <= '0;
        end else begin
            state_q    <= state_d;
            depth_q    <= depth_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
            mv_loc_q   <= mv_loc_d;
        end
    end

    assign bus.mv_loc = mv_loc_q;
    assign depth      = depth_q;
    assign overflow   = overflow_q;
    assign finish     = (state_q == S_FINISH);
    assign fail       = (state_q == S_FAIL);

endmodule

// File: tb/tb_path_replay_ctrl.sv
// -----------------------------------------------------------------------------
// tb_path_replay_ctrl
//   Bench for path_replay_ctrl. Contains a behavioural stack (the device the
//   controller drives), a phase-level reference model that predicts every
//   controller output each cycle, and directed solver scenarios with
//   hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_path_replay_ctrl;

    localparam int LOC_W   = 8;
    localparam int MAX_LEN = 63;
    localparam int CNT_W   = 6;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             slv_push = 1'b0;
    logic             slv_pop = 1'b0;
    logic [LOC_W-1:0] slv_loc = '0;
    logic             slv_found = 1'b0;
    logic             slv_fail = 1'b0;
    logic [CNT_W-1:0] depth;
    logic             overflow;
    logic             finish;
    logic             fail;

    int total = 0;
    int bad   = 0;

    path_replay_ctrl_if #(.LOC_W(LOC_W)) bus ();

    path_replay_ctrl #(
        .LOC_W  (LOC_W),
        .MAX_LEN(MAX_LEN),
        .CNT_W  (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .slv_push (slv_push),
        .slv_pop  (slv_pop),
        .slv_loc  (slv_loc),
        .slv_found(slv_found),
        .slv_fail (slv_fail),
        .bus      (bus),
        .depth    (depth),
        .overflow (overflow),
        .finish   (finish),
        .fail     (fail)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // ---------------- behavioural stack ----------------
    logic [LOC_W-1:0] stk_mem[$];
    int               stk_n;
    logic             q_mode;
    logic [LOC_W-1:0] stk_out;

    always @(posedge clk) begin
        if (!rst) begin
            stk_mem.delete();
            stk_n   <= 0;
            q_mode  <= 1'b0;
            stk_out <= '0;
        end else begin
            if (bus.stk_done) q_mode <= 1'b1;
            if (bus.stk_rst) begin
                stk_mem.delete();
                stk_n <= 0;
            end else if (bus.stk_push) begin
                stk_mem.push_back(bus.stk_locIn);
                stk_n <= stk_n + 1;
            end else if (bus.stk_pop && stk_mem.size() > 0) begin
                stk_out <= q_mode ? stk_mem.pop_front() : stk_mem.pop_back();
                stk_n   <= stk_n - 1;
            end
        end
    end

    assign bus.stk_empty  = (stk_n == 0);
    assign bus.stk_locOut = stk_out;

    // ---------------- reference model ----------------
    typedef enum int {M_IDLE, M_CLEAR, M_SOLVE, M_DONE, M_REPLAY, M_FIN, M_FAIL} mphase_t;

    bit               model_en = 1'b0;
    mphase_t          m_ph = M_IDLE;
    int               m_depth = 0;
    bit               m_ovf = 1'b0;
    logic [LOC_W-1:0] m_path[$];
    logic [LOC_W-1:0] m_order[$];
    int               m_step = 0;
    int               m_sent = 0;

    logic [LOC_W-1:0] got_log[$];
    int               done_cnt = 0;
    int               pop_cnt = 0;

    always @(negedge clk) begin : compare
        bit      e_rst, e_push, e_pop, e_done, e_valid, ovf_try;
        mphase_t nx;
        int      nd;
        if (model_en) begin
            e_rst = 0; e_push = 0; e_pop = 0; e_done = 0; e_valid = 0; ovf_try = 0;
            nx = m_ph;
            nd = m_depth;
            case (m_ph)
                M_IDLE:  if (start) nx = M_CLEAR;
                M_CLEAR: begin
                    e_rst = 1; nd = 0; m_path.delete(); nx = M_SOLVE;
                end
                M_SOLVE: begin
                    if (slv_push) begin
                        if (m_depth < MAX_LEN) begin
                            e_push = 1; nd = m_depth + 1; m_path.push_back(slv_loc);
                        end else begin
                            ovf_try = 1;
                        end
                    end else if (slv_pop && m_depth > 0) begin
                        e_pop = 1; nd = m_depth - 1; void'(m_path.pop_back());
                    end
                    if (slv_fail || ovf_try) nx = M_FAIL;
                    else if (slv_found) begin
                        m_order.delete();
                        m_sent = 0;
                        m_step = 0;
`ifdef REPLAY_REVERSE_EN
                        foreach (m_path[i]) m_order.push_front(m_path[i]);
                        nx = (nd == 0) ? M_FIN : M_REPLAY;
`else
                        foreach (m_path[i]) m_order.push_back(m_path[i]);
                        nx = M_DONE;
`endif
                    end
                end
                M_DONE: begin
                    e_done = 1;
                    nx = (m_depth == 0) ? M_FIN : M_REPLAY;
                end
                M_REPLAY: begin
                    if (m_step == 0) begin
                        e_pop = 1; m_step = 1;
                    end else if (m_step == 1) begin
                        m_step = 2;
                    end else begin
                        e_valid = 1;
                        if (m_sent < m_order.size())
                            check("mv_loc", bus.mv_loc, m_order[m_sent]);
                        if (bus.mv_ready) begin
                            m_sent++;
                            m_step = 0;
                            if (m_sent == m_depth) nx = M_FIN;
                        end
                    end
                end
                default: ;
            endcase

            check("stk_rst",  bus.stk_rst,  e_rst);
            check("stk_push", bus.stk_push, e_push);
            check("stk_pop",  bus.stk_pop,  e_pop);
            check("stk_done", bus.stk_done, e_done);
            check("mv_valid", bus.mv_valid, e_valid);
            if (e_push) check("stk_locIn", bus.stk_locIn, slv_loc);
            check("depth",    depth,    m_depth);
            check("overflow", overflow, m_ovf);
            check("finish",   finish,   m_ph == M_FIN);
            check("fail",     fail,     m_ph == M_FAIL);

            if (bus.mv_valid && bus.mv_ready) got_log.push_back(bus.mv_loc);
            if (bus.stk_done) done_cnt++;
            if (bus.stk_pop)  pop_cnt++;

            if (!rst) begin
                m_ph = M_IDLE; m_depth = 0; m_ovf = 0;
            end else begin
                m_ph = nx; m_depth = nd;
                if (ovf_try) m_ovf = 1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit push, input bit pop, input logic [LOC_W-1:0] loc,
                         input bit found, input bit fl);
        slv_push = push; slv_pop = pop; slv_loc = loc; slv_found = found; slv_fail = fl;
        step();
        slv_push = 0; slv_pop = 0; slv_loc = '0; slv_found = 0; slv_fail = 0;
    endtask

    task automatic clear_logs();
        got_log.delete();
        done_cnt = 0;
        pop_cnt  = 0;
    endtask

    task automatic do_reset();
        rst = 0;
        step();
        rst = 1;
        clear_logs();
    endtask

    task automatic start_run();
        start = 1;
        step();
        start = 0;
        step();
    endtask

    task automatic wait_end(input int budget);
        int n = 0;
        while (!(finish || fail) && n < budget) begin
            step();
            n++;
        end
        check("end_timeout", finish || fail, 1);
    endtask

    task automatic check_log(input string nm, input logic [31:0] exp_packed, input int n);
        logic [31:0] p = '0;
        check({nm, "_len"}, got_log.size(), n);
        for (int i = 0; i < got_log.size() && i < 4; i++) p = {p[23:0], got_log[i]};
        check(nm, p, exp_packed);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        logic [LOC_W-1:0] held;
        int               p0;
        int               n;

        bus.mv_ready = 1'b1;
        repeat (2) step();
        rst = 1;
        model_en = 1;

        // Reset state
        check("rst_depth",    depth,         0);
        check("rst_mv_loc",   bus.mv_loc,    0);
        check("rst_mv_valid", bus.mv_valid,  0);
        check("rst_flags",    {overflow, finish, fail}, 0);
        check("rst_stk",      {bus.stk_rst, bus.stk_push, bus.stk_pop, bus.stk_done}, 0);
        check("rst_locIn",    bus.stk_locIn, 0);

        // Three pushes then found, consumer always ready
        start_run();
        drive(1, 0, 8'h11, 0, 0);
        drive(1, 0, 8'h12, 0, 0);
        drive(1, 0, 8'h22, 0, 0);
        drive(0, 0, 8'h00, 1, 0);
        wait_end(60);
        check("t1_finish", finish, 1);
        check("t1_depth",  depth,  3);
        check("t1_pops",   pop_cnt, 3);
`ifdef REPLAY_REVERSE_EN
        check_log("t1_log", 32'h00221211, 3);
        check("t1_done", done_cnt, 0);
`else
        check_log("t1_log", 32'h00111222, 3);
        check("t1_done", done_cnt, 1);
`endif

        // Backtrack in the middle of the path
        do_reset();
        start_run();
        drive(1, 0, 8'h11, 0, 0);
        drive(1, 0, 8'h12, 0, 0);
        drive(0, 1, 8'h00, 0, 0);
        drive(1, 0, 8'h21, 0, 0);
        drive(0, 0, 8'h00, 1, 0);
        check("t2_depth", depth, 2);
        wait_end(60);
        check("t2_finish", finish, 1);
`ifdef REPLAY_REVERSE_EN
        check_log("t2_log", 32'h00002111, 2);
`else
        check_log("t2_log", 32'h00001121, 2);
`endif

        // Fill to MAX_LEN, then one push too many
        do_reset();
        start_run();
        for (int i = 0; i < MAX_LEN; i++) drive(1, 0, LOC_W'(i), 0, 0);
        check("t3_full", depth, 63);
        slv_push = 1; slv_loc = 8'hAA;
        @(negedge clk);
        check("t3_push_blocked", bus.stk_push, 0);
        step();
        slv_push = 0; slv_loc = '0;
        repeat (4) step();
        check("t3_overflow", overflow, 1);
        check("t3_fail",     fail,     1);
        check("t3_finish",   finish,   0);
        check("t3_depth",    depth,    63);
        check("t3_no_replay", got_log.size(), 0);

        // Push/pop collision and pop on empty
        do_reset();
        start_run();
        drive(1, 0, 8'h10, 0, 0);
        slv_push = 1; slv_pop = 1; slv_loc = 8'h20;
        @(negedge clk);
        check("t4_both_push", bus.stk_push, 1);
        check("t4_both_pop",  bus.stk_pop,  0);
        step();
        slv_push = 0; slv_pop = 0; slv_loc = '0;
        check("t4_depth2", depth, 2);
        drive(0, 1, 8'h00, 0, 0);
        drive(0, 1, 8'h00, 0, 0);
        slv_pop = 1;
        @(negedge clk);
        check("t4_underflow_pop", bus.stk_pop, 0);
        step();
        slv_pop = 0;
        check("t4_depth0", depth, 0);
        drive(0, 0, 8'h00, 1, 0);
        wait_end(20);
        check("t4_finish", finish, 1);
        check("t4_no_replay", got_log.size(), 0);

        // Consumer stall in R_HOLD, then reset mid-replay
        do_reset();
        bus.mv_ready = 1'b0;
        start_run();
        drive(1, 0, 8'h33, 0, 0);
        drive(1, 0, 8'h44, 0, 0);
        drive(0, 0, 8'h00, 1, 0);
        n = 0;
        while (!bus.mv_valid && n < 20) begin
            step();
            n++;
        end
        check("t5_valid_timeout", bus.mv_valid, 1);
`ifdef REPLAY_REVERSE_EN
        held = 8'h44;
`else
        held = 8'h33;
`endif
        p0 = pop_cnt;
        repeat (5) begin
            step();
            check("t5_hold_valid", bus.mv_valid, 1);
            check("t5_hold_loc",   bus.mv_loc,   held);
        end
        check("t5_no_extra_pop", pop_cnt, p0);
        rst = 0;
        step();
        check("t5_rst_depth", depth,        0);
        check("t5_rst_valid", bus.mv_valid, 0);
        check("t5_rst_loc",   bus.mv_loc,   0);
        check("t5_rst_flags", {overflow, finish, fail}, 0);
        check("t5_rst_stk",   {bus.stk_rst, bus.stk_push, bus.stk_pop, bus.stk_done}, 0);
        rst = 1;
        bus.mv_ready = 1'b1;
        clear_logs();

        // Order check with a short ascending path
        start_run();
        drive(1, 0, 8'h01, 0, 0);
        drive(1, 0, 8'h02, 0, 0);
        drive(1, 0, 8'h03, 0, 0);
        drive(0, 0, 8'h00, 1, 0);
        wait_end(60);
        check("t6_finish", finish, 1);
`ifdef REPLAY_REVERSE_EN
        check_log("t6_log", 32'h00030201, 3);
        check("t6_done", done_cnt, 0);
`else
        check_log("t6_log", 32'h00010203, 3);
        check("t6_done", done_cnt, 1);
`endif

        // Solver failure wins over found in the same cycle
        do_reset();
        start_run();
        drive(1, 0, 8'h55, 0, 0);
        drive(0, 0, 8'h00, 1, 1);
        repeat (3) step();
        check("t7_fail",   fail,   1);
        check("t7_finish", finish, 0);
        check("t7_no_replay", got_log.size(), 0);

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
